// File: rtl/marquee_pkg.sv
`default_nettype none
// ============================================================================
// Module      : marquee_pkg
// Description : Shared types and constants for the scrolling seven-segment
//               marquee: controller state encoding, active-low segment
//               patterns for decimal digits, and the blank pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package marquee_pkg;

    // Controller states; width fixed to one bit.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // All segments (including dp) off in active-low form.
    localparam logic [7:0] c_seg_blank = 8'hFF;

    // Active-low {dp,g..a} patterns for digits 0..9, dp off.
    localparam logic [7:0] c_seg_table [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    // Map a 4-bit character code to its active-low pattern; 10-15 are blank.
    function automatic logic [7:0] seg_decode(input logic [3:0] code);
        logic [7:0] pat;
        pat = c_seg_blank;
        for (int k = 0; k < 10; k++) begin
            if (code == 4'(k)) begin
                pat = c_seg_table[k];
            end
        end
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : tick_divider
// Description : Free-running modulo-DIV counter producing a one-cycle pulse
//               whenever the count sits at DIV-1.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int                 c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Count 0..DIV-1 and wrap; never stops, independent of controller state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/scroll_sseg_marquee.sv
`default_nettype none
// ============================================================================
// Module      : scroll_sseg_marquee
// Description : Scrolling message on a multiplexed seven-segment display.
//               Holds an active message plus a one-deep shadow that is
//               promoted when the scroll position wraps. Digit i shows
//               message character p-i-1 (blank when outside the message).
//               Optional feature macro SSEG_DP_HEARTBEAT_EN: dp of digit 0
//               toggles on every scroll tick while running.
// Revision    : 1.0 - initial release
// ============================================================================
module scroll_sseg_marquee
    import marquee_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int MSG_LEN        = 9,
    parameter int REFRESH_DIV    = 50000,
    parameter int SCROLL_DIV     = 2000000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*MSG_LEN-1:0]    msg_data,
    input  logic                    msg_valid,
    output logic                    msg_ready,
    input  logic                    scroll_en,
    input  logic                    dir,
    input  logic                    clear,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int                 c_pos_cnt  = MSG_LEN + NUM_DIGITS;
    localparam int                 c_pos_w    = $clog2(c_pos_cnt);
    localparam int                 c_idx_w    = $clog2(NUM_DIGITS);
    localparam int                 c_ext_w    = c_pos_w + 1;
    localparam logic [c_pos_w-1:0] c_pos_last = c_pos_w'(c_pos_cnt - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_pos_w-1:0]      r_pos;
    logic [c_idx_w-1:0]      r_idx;
    logic [4*MSG_LEN-1:0]    r_active;
    logic [4*MSG_LEN-1:0]    r_shadow;
    logic                    r_shadow_vld;
    logic                    r_frame;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_refresh_tick;
    logic                    w_scroll_tick;
    logic                    w_msg_ready;
    logic                    w_xfer;
    logic                    w_step;
    logic                    w_wrap;
    logic [c_pos_w-1:0]      w_pos_next;
    logic [c_ext_w-1:0]      w_pos_ext;
    logic [c_ext_w-1:0]      w_idx_ext;
    logic [c_ext_w-1:0]      w_char_pos;
    logic [3:0]              w_code;
    logic [7:0]              w_seg_next;
    logic [NUM_DIGITS-1:0]   w_an_next;

    tick_divider #(.DIV(REFRESH_DIV)) u_refresh_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_refresh_tick)
    );

    tick_divider #(.DIV(SCROLL_DIV)) u_scroll_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_scroll_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake: clear wins over everything, including a transfer.
    always_comb begin
        w_state_next = r_state;
        w_msg_ready  = 1'b0;
        if (!clear) begin
            w_msg_ready = (r_state == ST_IDLE) || !r_shadow_vld;
        end
        case (r_state)
            ST_IDLE: if (msg_valid && w_msg_ready) w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_IDLE;
        endcase
        if (clear) begin
            w_state_next = ST_IDLE;
        end
    end

    assign msg_ready = w_msg_ready;
    assign w_xfer    = msg_valid && w_msg_ready;
    assign w_step    = (r_state == ST_RUN) && w_scroll_tick && scroll_en && !clear;

    // Candidate scroll position and wrap detection for the current direction.
    always_comb begin
        w_pos_next = r_pos;
        w_wrap     = 1'b0;
        if (!dir) begin
            if (r_pos == c_pos_last) begin
                w_pos_next = '0;
                w_wrap     = 1'b1;
            end else begin
                w_pos_next = r_pos + c_pos_w'(1);
            end
        end else begin
            if (r_pos == '0) begin
                w_pos_next = c_pos_last;
                w_wrap     = 1'b1;
            end else begin
                w_pos_next = r_pos - c_pos_w'(1);
            end
        end
    end

    // Message buffers, scroll position, digit index and wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos        <= '0;
            r_idx        <= '0;
            r_active     <= '0;
            r_shadow     <= '0;
            r_shadow_vld <= 1'b0;
            r_frame      <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            if (clear) begin
                r_pos        <= '0;
                r_idx        <= '0;
                r_shadow_vld <= 1'b0;
            end else if (r_state == ST_IDLE) begin
                if (w_xfer) begin
                    r_active <= msg_data;
                    r_pos    <= '0;
                end
            end else begin
                if (w_refresh_tick) begin
                    r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
                end
                if (w_step) begin
                    r_pos <= w_pos_next;
                    if (w_wrap) begin
                        r_frame <= 1'b1;
                        // Only a message already waiting is promoted; one
                        // arriving on this same edge waits for the next wrap.
                        if (r_shadow_vld) begin
                            r_active     <= r_shadow;
                            r_shadow_vld <= 1'b0;
                        end
                    end
                end
                if (w_xfer) begin
                    r_shadow     <= msg_data;
                    r_shadow_vld <= 1'b1;
                end
            end
        end
    end

`ifdef SSEG_DP_HEARTBEAT_EN
    logic r_hb;

    // Heartbeat flips on every scroll tick while running, even when frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hb <= 1'b0;
        end else if ((r_state == ST_RUN) && w_scroll_tick && !clear) begin
            r_hb <= ~r_hb;
        end
    end
`endif

    // Character lookup for the digit being scanned: char = p - idx - 1.
    always_comb begin
        w_pos_ext  = c_ext_w'(r_pos);
        w_idx_ext  = c_ext_w'(r_idx);
        w_char_pos = '0;
        w_code     = 4'hF;
        if (w_pos_ext > w_idx_ext) begin
            w_char_pos = w_pos_ext - w_idx_ext - c_ext_w'(1);
            for (int k = 0; k < MSG_LEN; k++) begin
                if (w_char_pos == c_ext_w'(k)) begin
                    w_code = r_active[4*(MSG_LEN-1-k) +: 4];
                end
            end
        end
        w_seg_next = seg_decode(w_code);
`ifdef SSEG_DP_HEARTBEAT_EN
        if (r_idx == '0) begin
            w_seg_next[7] = ~r_hb;
        end
`endif
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_an_next[k] = (r_idx != c_idx_w'(k));
        end
    end

    // Registered display drive; dark whenever idle or being cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= c_seg_blank;
            r_an  <= '1;
        end else if (clear || (r_state != ST_RUN)) begin
            r_seg <= c_seg_blank;
            r_an  <= '1;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    generate
        if (SEG_ACTIVE_LOW != 0) begin : g_active_low
            assign seg = r_seg;
            assign an  = r_an;
        end else begin : g_active_high
            assign seg = ~r_seg;
            assign an  = ~r_an;
        end
    endgenerate

    assign frame_start = r_frame;

endmodule
`default_nettype wire

// File: doc/scroll_sseg_marquee.md
SCROLL_SSEG_MARQUEE -- requirements
Module: scroll_sseg_marquee

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of multiplexed seven-segment digits (2..8).
REQ-002 SHALL have parameter MSG_LEN, default 9, number of 4-bit characters per message (1..16).
REQ-003 SHALL have parameter REFRESH_DIV, default 50000, clk cycles per digit-scan step (>=2).
REQ-004 SHALL have parameter SCROLL_DIV, default 2000000, clk cycles per scroll step (>=2).
REQ-005 SHALL have parameter SEG_ACTIVE_LOW, default 1; 1 = segments and anodes driven low-active, 0 = both outputs inverted.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  system clock, all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 msg_data  input  4*MSG_LEN  message; char 0 = msg_data[4*MSG_LEN-1 -: 4]; codes 0-9 digits, 10-15 blank.
REQ-009 msg_valid  input  1  message offered; msg_ready  output  1  message can be accepted.
REQ-010 scroll_en  input  1  1 = scroll position advances; dir  input  1  0 = text moves left, 1 = right.
REQ-011 clear  input  1  synchronous return to IDLE.
REQ-012 seg  output  8  segments {dp,g..a}; an  output  NUM_DIGITS  digit enables, bit 0 = rightmost digit.
REQ-013 frame_start  output  1  one-cycle pulse when scroll position wraps.

Function
REQ-014 SHALL implement states IDLE and RUN; IDLE: an all off, seg all off, msg_ready=1.
REQ-015 Transfer SHALL occur on rising clk with msg_valid && msg_ready; in IDLE transferred msg loads active register, p=0, state RUN next cycle.
REQ-016 In RUN msg_ready SHALL equal "shadow empty"; transfer writes shadow, msg_ready=0 from next cycle.
REQ-017 Shadow SHALL be promoted to active on the scroll tick that wraps p; msg_ready=1 the following cycle.
REQ-018 Scroll position p SHALL range 0..P-1, P = MSG_LEN+NUM_DIGITS; on scroll tick with scroll_en=1: dir=0 p increments, P-1 wraps to 0; dir=1 p decrements, 0 wraps to P-1.
REQ-019 Digit i SHALL show char c = p-i-1; c outside 0..MSG_LEN-1 or code 10-15 displays blank (all segments off).
REQ-020 Digit index SHALL advance 0..NUM_DIGITS-1 on each refresh tick and wrap; exactly one an bit active in RUN.
REQ-021 seg/an SHALL be registered, reflecting digit index and p one cycle earlier; patterns (active-low) 0..9 = C0,F9,A4,B0,99,92,82,F8,80,90 hex.
REQ-022 scroll_en=0 SHALL freeze p while scanning continues; dir change takes effect on next scroll tick.
REQ-023 frame_start SHALL pulse on the same cycle p wraps.
REQ-024 Transfer and wrap in same cycle: new msg goes to shadow, promoted at the next wrap, not this one.
REQ-025 clear SHALL have priority: msg_ready forced 0 that cycle, no transfer, shadow emptied, state IDLE, p=0, index 0.
REQ-026 Tick counters SHALL run 0..DIV-1, pulse at DIV-1, free-running in both states.

Reset
REQ-027 While rst_n=0: state IDLE, p=0, index 0, counters 0, shadow empty, seg=FF/an all ones (SEG_ACTIVE_LOW=1), frame_start=0, msg_ready=1.

Configuration
REQ-028 With SSEG_DP_HEARTBEAT_EN defined, dp of digit 0 SHALL toggle on every scroll tick in RUN; without it dp SHALL stay off on all digits.

Structure
REQ-029 Package marquee_pkg SHALL hold the segment pattern table, blank pattern, and state enum.
REQ-030 Sub-module tick_divider (parameter DIV, outputs one-cycle pulse) SHALL be instantiated twice (refresh, scroll).

Verification (NUM_DIGITS=4, MSG_LEN=3, REFRESH_DIV=2, SCROLL_DIV=16)
REQ-031 Reset mid-RUN -> seg=FF, an=F, msg_ready=1 immediately, state IDLE.
REQ-032 Load 0x123 in IDLE, scroll to p=2 -> digit0 seg=A4, digit1 seg=F9, digits 2-3 seg=FF.
REQ-033 Continuous scroll dir=0 -> frame_start every 7*16 cycles at p 6->0; dir=1 from p=0 -> p=6 next tick.
REQ-034 Load 0x456 in RUN -> msg_ready=0 until wrap; after wrap, p=1 digit0 shows '4' (99).
REQ-035 clear and msg_valid in same cycle -> no transfer, IDLE, an=F next cycle.
REQ-036 scroll_en=0 for 64 cycles -> p unchanged, an continues cycling E,D,B,7.
